// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single combinational-read data memory.
// Port 0 is the CPU datapath, port 1 the board-side debug/display scanner.
// Each access runs Idle -> Busy -> Done; out-of-range requests are flagged and never
// strobe the memory.
module dmem_arbiter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_memWrite,
  output logic              mem_memRead,
  input  logic [DATA_W-1:0] mem_readData,
  output logic              busy
);

  // A word write touches addr..addr+3, so its last legal start is four bytes from the end.
  localparam logic [ADDR_W-1:0] WrMax = ADDR_W'(MEM_BYTES - 4);
  localparam logic [ADDR_W-1:0] RdMax = ADDR_W'(MEM_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            stateQ, stateD;
  logic              lastQ, selQ, weQ, inRangeQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic              ack0Q, ack1Q, err0Q, err1Q;
  logic [DATA_W-1:0] rdata0Q, rdata1Q;

  logic              anyReq, grantSel, selWe, selInRange;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;

  // Grant selection: a lone requester wins; on a tie the port that did not go last wins.
  always_comb begin
    anyReq     = req0 | req1;
    grantSel   = (req0 & req1) ? ~lastQ : req1;
    selWe      = grantSel ? we1 : we0;
    selAddr    = grantSel ? addr1 : addr0;
    selWdata   = grantSel ? wdata1 : wdata0;
    selInRange = selWe ? (selAddr <= WrMax) : (selAddr <= RdMax);
  end

  // State register.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) stateQ <= StIdle;
    else       stateQ <= stateD;
  end

  // Next-state logic: fixed three-cycle access.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StIdle:  if (anyReq) stateD = StBusy;
      StBusy:  stateD = StDone;
      StDone:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  // Memory strobes only during Busy of an in-range access.
  always_comb begin
    mem_memWrite = 1'b0;
    mem_memRead  = 1'b0;
    busy         = (stateQ != StIdle);
    if (stateQ == StBusy && inRangeQ) begin
      mem_memWrite = weQ;
      mem_memRead  = ~weQ;
    end
  end

  // Request latches, per-port completion flags and read-data registers.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      lastQ    <= 1'b1;
      selQ     <= 1'b0;
      weQ      <= 1'b0;
      inRangeQ <= 1'b0;
      addrQ    <= '0;
      wdataQ   <= '0;
      ack0Q    <= 1'b0;
      ack1Q    <= 1'b0;
      err0Q    <= 1'b0;
      err1Q    <= 1'b0;
      rdata0Q  <= '0;
      rdata1Q  <= '0;
    end else begin
      case (stateQ)
        StIdle: begin
          if (anyReq) begin
            selQ     <= grantSel;
            lastQ    <= grantSel;
            weQ      <= selWe;
            inRangeQ <= selInRange;
            // Rejected requests leave the memory bus holding its previous value.
            if (selInRange) begin
              addrQ  <= selAddr;
              wdataQ <= selWdata;
            end
          end
        end
        StBusy: begin
          if (!selQ) begin
            ack0Q <= 1'b1;
            err0Q <= ~inRangeQ;
            if (!inRangeQ)  rdata0Q <= '0;
            else if (!weQ)  rdata0Q <= mem_readData;
          end else begin
            ack1Q <= 1'b1;
            err1Q <= ~inRangeQ;
            if (!inRangeQ)  rdata1Q <= '0;
            else if (!weQ)  rdata1Q <= mem_readData;
          end
        end
        StDone: begin
          ack0Q <= 1'b0;
          ack1Q <= 1'b0;
          err0Q <= 1'b0;
          err1Q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_address   = addrQ;
  assign mem_writeData = wdataQ;
  assign ack0          = ack0Q;
  assign ack1          = ack1Q;
  assign err0          = err0Q;
  assign err1          = err1Q;
  assign rdata0        = rdata0Q;
  assign rdata1        = rdata1Q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised self-checking bench for dmem_arbiter with an attached byte memory and a
// byte-array reference model of the expected memory contents and per-port read data.
module tb_dmem_arbiter;

  logic        clock_in = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_address, mem_writeData, mem_readData;
  logic        mem_memWrite, mem_memRead, busy;

  int nChecks = 0;
  int nErrors = 0;

  logic [7:0]  mem [128];
  logic [7:0]  refMem [128];
  logic [31:0] expRd [2];
  bit          memInit = 1'b1;

  always #5 clock_in = ~clock_in;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_BYTES(128)) dut (
    .clock_in(clock_in), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
    .mem_readData(mem_readData), .busy(busy)
  );

  // Attached memory: byte i initially holds i, byte read, big-endian word write on negedge.
  always_comb begin
    mem_readData = '0;
    if (mem_address < 32'd128) mem_readData = {24'b0, mem[mem_address[6:0]]};
  end

  always @(negedge clock_in) begin
    if (memInit) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'(i);
      memInit <= 1'b0;
    end else if (mem_memWrite) begin
      for (int k = 0; k < 4; k++)
        if (mem_address + 32'(k) < 32'd128)
          mem[7'(mem_address + 32'(k))] <= mem_writeData[31-8*k -: 8];
    end
  end

  function automatic logic ackOf(input int p);
    return p ? ack1 : ack0;
  endfunction

  function automatic logic errOf(input int p);
    return p ? err1 : err0;
  endfunction

  function automatic logic [31:0] rdataOf(input int p);
    return p ? rdata1 : rdata0;
  endfunction

  task automatic set_port(input int p, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  // One complete access on a single port, checked cycle by cycle against the model.
  task automatic do_access(input int p, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input string name);
    logic        inR;
    logic [31:0] expR, otherRd;
    int          wrCnt, rdCnt;
    bit          got;
    inR = w ? (a <= 32'd124) : (a <= 32'd127);
    if (!inR)   expR = '0;
    else if (w) expR = expRd[p];
    else        expR = {24'b0, refMem[a[6:0]]};
    otherRd = expRd[1-p];
    got = 0; wrCnt = 0; rdCnt = 0;
    set_port(p, 1'b1, w, a, d);
    for (int cyc = 1; cyc <= 8 && !got; cyc++) begin
      @(posedge clock_in); #1;
      if (mem_memWrite) wrCnt++;
      if (mem_memRead)  rdCnt++;
      nChecks++;
      if (ackOf(1-p) !== 1'b0) begin
        nErrors++; $display("FAIL %s wrong_port_ack cyc=%0d got=%b want=0", name, cyc, ackOf(1-p));
      end
      if (ackOf(p) === 1'b1) begin
        got = 1;
        nChecks++;
        if (cyc != 2) begin
          nErrors++; $display("FAIL %s ack_latency got=%0d want=2", name, cyc);
        end
        nChecks++;
        if (errOf(p) !== !inR) begin
          nErrors++; $display("FAIL %s err got=%b want=%b", name, errOf(p), !inR);
        end
        nChecks++;
        if (rdataOf(p) !== expR) begin
          nErrors++; $display("FAIL %s rdata got=%h want=%h", name, rdataOf(p), expR);
        end
        nChecks++;
        if (busy !== 1'b1 || mem_memWrite !== 1'b0 || mem_memRead !== 1'b0) begin
          nErrors++; $display("FAIL %s done_state busy=%b wr=%b rd=%b want 1,0,0", name, busy,
                              mem_memWrite, mem_memRead);
        end
      end else if (cyc == 1) begin
        nChecks++;
        if (busy !== 1'b1 || mem_memWrite !== (inR & w) || mem_memRead !== (inR & !w)) begin
          nErrors++; $display("FAIL %s busy_state busy=%b wr=%b rd=%b want 1,%b,%b", name, busy,
                              mem_memWrite, mem_memRead, inR & w, inR & !w);
        end
        if (inR) begin
          nChecks++;
          if (mem_address !== a || (w && mem_writeData !== d)) begin
            nErrors++; $display("FAIL %s mem_bus addr=%h data=%h want %h,%h", name, mem_address,
                                mem_writeData, a, d);
          end
        end
      end
    end
    if (!got) begin
      nChecks++; nErrors++; $display("FAIL %s ack_timeout got=none want=ack%0d", name, p);
    end
    set_port(p, 1'b0, w, a, d);
    if (inR && w) for (int k = 0; k < 4; k++) refMem[7'(a + 32'(k))] = d[31-8*k -: 8];
    expRd[p] = expR;
    nChecks++;
    if (wrCnt != int'(inR && w) || rdCnt != int'(inR && !w)) begin
      nErrors++; $display("FAIL %s strobe_count wr=%0d rd=%0d want %0d,%0d", name, wrCnt, rdCnt,
                          int'(inR && w), int'(inR && !w));
    end
    @(posedge clock_in); #1;
    nChecks++;
    if (ack0 !== 1'b0 || ack1 !== 1'b0 || err0 !== 1'b0 || err1 !== 1'b0 || busy !== 1'b0) begin
      nErrors++; $display("FAIL %s back_idle ack=%b%b err=%b%b busy=%b want all 0", name, ack1,
                          ack0, err1, err0, busy);
    end
    nChecks++;
    if (rdataOf(1-p) !== otherRd) begin
      nErrors++; $display("FAIL %s other_rdata got=%h want=%h", name, rdataOf(1-p), otherRd);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clock_in);
    #1;
    expRd[0] = '0; expRd[1] = '0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 128; i++) refMem[i] = 8'(i);
    apply_reset();
    nChecks++;
    if (ack0 !== 0 || ack1 !== 0 || err0 !== 0 || err1 !== 0 || busy !== 0 ||
        mem_memWrite !== 0 || mem_memRead !== 0) begin
      nErrors++; $display("FAIL reset_flags ack=%b%b err=%b%b busy=%b wr=%b rd=%b want all 0",
                          ack1, ack0, err1, err0, busy, mem_memWrite, mem_memRead);
    end
    nChecks++;
    if (rdata0 !== 0 || rdata1 !== 0 || mem_address !== 0 || mem_writeData !== 0) begin
      nErrors++; $display("FAIL reset_data rd0=%h rd1=%h addr=%h wd=%h want all 0", rdata0,
                          rdata1, mem_address, mem_writeData);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_access(0, 1'b0, 32'd5, '0, "read5");
    do_access(1, 1'b1, 32'd0, 32'h11223344, "write0");
    for (int i = 0; i < 4; i++) do_access(i % 2, 1'b0, 32'(i), '0, "readback");
  endtask

  task automatic test_range();
    do_access(0, 1'b1, 32'd126, $urandom, "write126");
    do_access(0, 1'b0, 32'd126, '0, "read126");
    do_access(1, 1'b0, 32'd127, '0, "read127");
    do_access(1, 1'b0, 32'd128, '0, "read128");
    do_access(0, 1'b1, 32'd124, $urandom, "write124");
    do_access(1, 1'b1, 32'd125, $urandom, "write125");
  endtask

  // Both ports held requesting; grants must alternate starting with port 0 every 3 cycles.
  task automatic test_tie(input int n, input bit fromReset, input string name);
    logic [31:0] a [2];
    int nAck, lastCyc, expPort, pa;
    a[0] = 32'($urandom_range(0, 127));
    a[1] = 32'($urandom_range(0, 127));
    if (fromReset) reset = 1'b1;
    set_port(0, 1'b1, 1'b0, a[0], '0);
    set_port(1, 1'b1, 1'b0, a[1], '0);
    if (fromReset) begin
      @(posedge clock_in); #1;
      expRd[0] = '0; expRd[1] = '0;
      reset = 1'b0;
    end
    nAck = 0; lastCyc = 0; expPort = 0;
    for (int cyc = 1; cyc <= 6 * n + 10 && nAck < n; cyc++) begin
      @(posedge clock_in); #1;
      if (ack0 === 1'b1 && ack1 === 1'b1) begin
        nChecks++; nErrors++; $display("FAIL %s double_ack cyc=%0d got=11 want one", name, cyc);
      end else if (ack0 === 1'b1 || ack1 === 1'b1) begin
        pa = ack1 ? 1 : 0;
        nChecks++;
        if (pa != expPort) begin
          nErrors++; $display("FAIL %s grant_order n=%0d got=%0d want=%0d", name, nAck, pa,
                              expPort);
        end
        nChecks++;
        if (cyc - lastCyc != (nAck == 0 ? 2 : 3)) begin
          nErrors++; $display("FAIL %s ack_spacing got=%0d want=%0d", name, cyc - lastCyc,
                              nAck == 0 ? 2 : 3);
        end
        nChecks++;
        if (rdataOf(pa) !== {24'b0, refMem[a[pa][6:0]]}) begin
          nErrors++; $display("FAIL %s tie_rdata got=%h want=%h", name, rdataOf(pa),
                              {24'b0, refMem[a[pa][6:0]]});
        end
        expRd[pa] = {24'b0, refMem[a[pa][6:0]]};
        expPort = 1 - expPort;
        nAck++;
        lastCyc = cyc;
      end
    end
    if (nAck < n) begin
      nChecks++; nErrors++; $display("FAIL %s tie_timeout got=%0d want=%0d acks", name, nAck, n);
    end
    set_port(0, 1'b0, 1'b0, a[0], '0);
    set_port(1, 1'b0, 1'b0, a[1], '0);
    @(posedge clock_in); #1;
    nChecks++;
    if (busy !== 1'b0) begin
      nErrors++; $display("FAIL %s tie_idle busy got=%b want=0", name, busy);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] d;
    d = $urandom;
    set_port(0, 1'b1, 1'b1, 32'd8, d);
    @(posedge clock_in); #1;
    nChecks++;
    if (mem_memWrite !== 1'b1) begin
      nErrors++; $display("FAIL midrst_pre_wr got=%b want=1", mem_memWrite);
    end
    reset = 1'b1;
    #1;
    nChecks++;
    if (mem_memWrite !== 1'b0 || busy !== 1'b0) begin
      nErrors++; $display("FAIL midrst_drop wr=%b busy=%b want 0,0", mem_memWrite, busy);
    end
    set_port(0, 1'b0, 1'b0, '0, '0);
    expRd[0] = '0; expRd[1] = '0;
    @(posedge clock_in); #1;
    nChecks++;
    if (ack0 !== 1'b0 || busy !== 1'b0) begin
      nErrors++; $display("FAIL midrst_noack ack0=%b busy=%b want 0,0", ack0, busy);
    end
    reset = 1'b0;
    test_tie(2, 1'b0, "tie_after_reset");
    do_access(1, 1'b0, 32'd8, '0, "midrst_read8");
  endtask

  task automatic test_random();
    int p;
    logic w;
    for (int i = 0; i < 40; i++) begin
      p = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      do_access(p, w, 32'($urandom_range(0, 131)), $urandom, "random");
      repeat ($urandom_range(0, 2)) @(posedge clock_in);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_range();
    test_tie(6, 1'b1, "tie_from_reset");
    test_reset_mid_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
